// File: rtl/sram_1p_arbiter_if.sv
// Requester-side bus of sram_1p_arbiter: read request, read response and write request.
// master = requester, slave = arbiter. Params: IDX_W (set index width), DATA_W (entry width).
interface sram_1p_arbiter_if #(
  parameter int IDX_W  = 6,
  parameter int DATA_W = 64
);
  logic              r_req_valid;
  logic              r_req_ready;
  logic [IDX_W-1:0]  r_req_idx;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              w_req_valid;
  logic              w_req_ready;
  logic [IDX_W-1:0]  w_req_idx;
  logic [DATA_W-1:0] w_req_data;

  modport master (
    output r_req_valid, r_req_idx,
    output w_req_valid, w_req_idx, w_req_data,
    input  r_req_ready, w_req_ready,
    input  r_resp_valid, r_resp_data
  );

  modport slave (
    input  r_req_valid, r_req_idx,
    input  w_req_valid, w_req_idx, w_req_data,
    output r_req_ready, w_req_ready,
    output r_resp_valid, r_resp_data
  );
endinterface

// File: rtl/sram_1p_arbiter.sv
// Read/write arbiter onto a single-port SRAM: bounded read starvation, held read data,
// optional post-reset zero-fill (macro SRAM_1P_ARB_INIT_EN).
// Ports: clock, reset (sync, active-low), req (slave bus), sram_* (SRAM wrapper), init_done.
module sram_1p_arbiter #(
  parameter  int SETS       = 64,
  parameter  int DATA_W     = 64,
  parameter  int STARVE_MAX = 4,
  localparam int IDX_W      = $clog2(SETS)
) (
  input  logic              clock,
  input  logic              reset,
  sram_1p_arbiter_if.slave  req,
  output logic              sram_rreq_valid,
  output logic [IDX_W-1:0]  sram_rreq_setIdx,
  input  logic [DATA_W-1:0] sram_rresp_data,
  output logic              sram_wreq_valid,
  output logic [IDX_W-1:0]  sram_wreq_setIdx,
  output logic [DATA_W-1:0] sram_wreq_data,
  output logic              init_done
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              resp_pend_q, resp_pend_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic run;
  logic starved;
  logic rd_acc;
  logic wr_acc;

  assign run     = (state_q == RUN);
  assign starved = (starve_cnt_q == SMAX);

  // Write has priority unless the reader has waited STARVE_MAX cycles.
  assign req.r_req_ready = run & (~req.w_req_valid | starved);
  assign req.w_req_ready = run & ~(req.r_req_valid & starved);

  assign rd_acc = req.r_req_valid & req.r_req_ready;
  assign wr_acc = req.w_req_valid & req.w_req_ready;

  assign sram_rreq_valid  = rd_acc;
  assign sram_rreq_setIdx = req.r_req_idx;
  assign init_done        = run;

`ifdef SRAM_1P_ARB_INIT_EN
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;

  assign sram_wreq_valid  = run ? wr_acc : 1'b1;
  assign sram_wreq_setIdx = run ? req.w_req_idx : init_cnt_q;
  assign sram_wreq_data   = run ? req.w_req_data : '0;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (!run) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == IDX_W'(SETS - 1)) state_d = RUN;
    end
  end
`else
  assign sram_wreq_valid  = wr_acc;
  assign sram_wreq_setIdx = req.w_req_idx;
  assign sram_wreq_data   = req.w_req_data;

  always_comb begin
    state_d = RUN;
  end
`endif

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (rd_acc) begin
      starve_cnt_d = '0;
    end else if (run && req.r_req_valid && !starved) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    resp_pend_d = rd_acc;
    hold_d      = resp_pend_q ? sram_rresp_data : hold_q;
  end

  // SRAM data arrives one cycle after issue; bypass it on that cycle, then hold it.
  assign req.r_resp_valid = resp_pend_q;
  assign req.r_resp_data  = resp_pend_q ? sram_rresp_data : hold_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
`ifdef SRAM_1P_ARB_INIT_EN
      state_q    <= INIT;
      init_cnt_q <= '0;
`else
      state_q    <= RUN;
`endif
      starve_cnt_q <= '0;
      resp_pend_q  <= 1'b0;
      hold_q       <= '0;
    end else begin
`ifdef SRAM_1P_ARB_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      resp_pend_q  <= resp_pend_d;
      hold_q       <= hold_d;
    end
  end

endmodule

// File: tb/tb_sram_1p_arbiter.sv
// Randomised scoreboard bench for sram_1p_arbiter with a behavioural SRAM
// and a spec-level reference model of arbitration, init and read data.
module tb_sram_1p_arbiter;
  localparam int SETS = 64;
  localparam int DW   = 64;
  localparam int IW   = 6;
  localparam int SM   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_1p_arbiter_if #(.IDX_W(IW), .DATA_W(DW)) bus ();

  logic          sram_rreq_valid;
  logic [IW-1:0] sram_rreq_setIdx;
  logic [DW-1:0] sram_rresp_data;
  logic          sram_wreq_valid;
  logic [IW-1:0] sram_wreq_setIdx;
  logic [DW-1:0] sram_wreq_data;
  logic          init_done;

  sram_1p_arbiter #(.SETS(SETS), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clock            (clk),
    .reset            (rst_n),
    .req              (bus),
    .sram_rreq_valid  (sram_rreq_valid),
    .sram_rreq_setIdx (sram_rreq_setIdx),
    .sram_rresp_data  (sram_rresp_data),
    .sram_wreq_valid  (sram_wreq_valid),
    .sram_wreq_setIdx (sram_wreq_setIdx),
    .sram_wreq_data   (sram_wreq_data),
    .init_done        (init_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Behavioural SRAM: write at the edge, read data registered for the next cycle.
  logic [DW-1:0] mem [SETS];
  logic [DW-1:0] ref_mem [SETS];
  logic sram_en = 1'b0;
  bit   m_known = 1'b0;

  always @(posedge clk) begin
    sram_en <= m_known;
    if (sram_en && sram_wreq_valid) mem[sram_wreq_setIdx] <= sram_wreq_data;
    if (sram_en && sram_rreq_valid) sram_rresp_data <= mem[sram_rreq_setIdx];
    else sram_rresp_data <= {$urandom, $urandom};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } exp_t;
  exp_t expq[$];

  // Reference model of arbitration/init, evaluated mid-cycle.
  bit m_run;
  int m_cnt;
  int m_starve;
  int rd_seen = 0;
  int wr_seen = 0;
  bit er, ew, ra, wa, stv;

  always @(negedge clk) begin
    if (m_known) begin
      stv = (m_starve == SM);
      er  = m_run && (!bus.w_req_valid || stv);
      ew  = m_run && !(bus.r_req_valid && stv);
      ra  = bus.r_req_valid && er;
      wa  = bus.w_req_valid && ew;
      chk("r_req_ready", 64'(bus.r_req_ready), 64'(er));
      chk("w_req_ready", 64'(bus.w_req_ready), 64'(ew));
      chk("init_done", 64'(init_done), 64'(m_run));
      chk("sram_rreq_valid", 64'(sram_rreq_valid), 64'(ra));
      if (ra) chk("sram_rreq_idx", 64'(sram_rreq_setIdx), 64'(bus.r_req_idx));
      if (bus.r_req_valid && bus.r_req_ready) rd_seen++;
      if (bus.w_req_valid && bus.w_req_ready) wr_seen++;
      if (!m_run) begin
        chk("init_wvalid", 64'(sram_wreq_valid), 64'd1);
        chk("init_widx", 64'(sram_wreq_setIdx), 64'(m_cnt));
        chk("init_wdata", sram_wreq_data, 64'd0);
        ref_mem[m_cnt] = '0;
      end else begin
        chk("sram_wreq_valid", 64'(sram_wreq_valid), 64'(wa));
        if (wa) begin
          chk("sram_widx", 64'(sram_wreq_setIdx), 64'(bus.w_req_idx));
          chk("sram_wdata", sram_wreq_data, bus.w_req_data);
          ref_mem[bus.w_req_idx] = bus.w_req_data;
        end
      end
      if (rst_n) begin
        if (ra) expq.push_back('{d: ref_mem[bus.r_req_idx], c: cyc + 1});
        if (!m_run) begin
          if (m_cnt == SETS - 1) m_run = 1'b1;
          m_cnt++;
        end else if (ra) begin
          m_starve = 0;
        end else if (bus.r_req_valid && m_starve < SM) begin
          m_starve++;
        end
      end
    end
    if (!rst_n) begin
      m_known  = 1'b1;
`ifdef SRAM_1P_ARB_INIT_EN
      m_run    = 1'b0;
`else
      m_run    = 1'b1;
`endif
      m_cnt    = 0;
      m_starve = 0;
    end
  end

  // Monitor: pops expected responses and checks hold behaviour.
  bit            mon_known = 1'b0;
  logic [DW-1:0] mon_hold = '0;
  bit            exp_v;
  exp_t          e;

  always @(negedge clk) begin
    if (mon_known) begin
      exp_v = (expq.size() > 0) && (expq[0].c == cyc);
      chk("r_resp_valid", 64'(bus.r_resp_valid), 64'(exp_v));
      if (exp_v) begin
        e = expq.pop_front();
        chk("r_resp_data", bus.r_resp_data, e.d);
        mon_hold = e.d;
      end else if (!bus.r_resp_valid) begin
        chk("r_resp_hold", bus.r_resp_data, mon_hold);
      end
    end
    if (!rst_n) begin
      mon_known = 1'b1;
      mon_hold  = '0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.r_req_valid = 1'b0;
    bus.w_req_valid = 1'b0;
  endtask

  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (!init_done) begin
      errors++;
      $display("FAIL init_timeout: got init_done=0 expected 1 after %0d cycles", n);
    end
  endtask

  task automatic do_write(input logic [IW-1:0] idx, input logic [DW-1:0] d);
    int n = 0;
    bus.w_req_valid = 1'b1;
    bus.w_req_idx   = idx;
    bus.w_req_data  = d;
    #1;
    while (!bus.w_req_ready && n < 50) begin
      step();
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: got no accept expected accept idx %0d", idx);
    end
    step();
    bus.w_req_valid = 1'b0;
  endtask

  task automatic do_read(input logic [IW-1:0] idx);
    int n = 0;
    bus.r_req_valid = 1'b1;
    bus.r_req_idx   = idx;
    #1;
    while (!bus.r_req_ready && n < 50) begin
      step();
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: got no accept expected accept idx %0d", idx);
    end
    step();
    bus.r_req_valid = 1'b0;
  endtask

  int r0, w0;

  initial begin
    for (int i = 0; i < SETS; i++) begin
      mem[i]     = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    idle_in();
    bus.r_req_idx  = '0;
    bus.w_req_idx  = '0;
    bus.w_req_data = '0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Init sweep, then read an untouched set
    wait_init();
    do_read(6'd37);
    repeat (2) step();

    // Write then read same set, hold for idle cycles
    do_write(6'd5, 64'hDEADBEEF_CAFEF00D);
    do_read(6'd5);
    repeat (4) step();

    // Starvation: write stream vs one read on set 9
    r0 = rd_seen;
    w0 = wr_seen;
    bus.r_req_valid = 1'b1;
    bus.r_req_idx   = 6'd9;
    bus.w_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.w_req_idx  = 6'(20 + i);
      bus.w_req_data = {$urandom, $urandom};
      step();
    end
    chk("starve_writes", 64'(wr_seen - w0), 64'd4);
    chk("starve_reads", 64'(rd_seen - r0), 64'd1);
    bus.r_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.w_req_idx  = 6'(30 + i);
      bus.w_req_data = {$urandom, $urandom};
      step();
    end
    chk("writes_resume", 64'(wr_seen - w0), 64'd6);
    idle_in();
    step();

    // Back-to-back reads
    for (int i = 1; i <= 3; i++) begin
      bus.r_req_valid = 1'b1;
      bus.r_req_idx   = 6'(i);
      step();
    end
    idle_in();
    repeat (3) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.r_req_valid = ($urandom_range(0, 2) != 0);
      bus.w_req_valid = ($urandom_range(0, 1) != 0);
      bus.r_req_idx   = 6'($urandom_range(0, 15));
      bus.w_req_idx   = 6'($urandom_range(0, 15));
      bus.w_req_data  = {$urandom, $urandom};
      step();
    end
    idle_in();
    repeat (2) step();

    // Reset in the cycle a read is accepted
    do_write(6'd5, 64'h0123_4567_89AB_CDEF);
    bus.r_req_valid = 1'b1;
    bus.r_req_idx   = 6'd5;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_in();
    wait_init();
    do_read(6'd5);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
